// File: rtl/timer_irq_sched.sv
// Four prescaled countdown channels with pending/mask bits, arbitrated
// round-robin onto one level interrupt, on the picorv32 native memory bus.
module timer_irq_sched (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic        mem_instr,
   input  logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_addr,
   output logic [31:0] mem_rdata,
   output logic        irq,
   output logic [1:0]  irq_id
);

   // state    | meaning
   // ---------+-----------------------------------------------------
   // ST_IDLE  | no grant; search pending&mask starting at ptr+1
   // ST_GRANT | irq high, irq_id held until ack, pend clear or mask

   typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} arb_state_e;

   localparam logic [3:0] A_CTRL  = 4'h8;
   localparam logic [3:0] A_PEND  = 4'h9;
   localparam logic [3:0] A_CUR   = 4'hA;
   localparam logic [3:0] A_PRESC = 4'hB;

   arb_state_e       state_q, state_d;
   logic [3:0][31:0] cnt_q, cnt_d;
   logic [3:0][31:0] rld_q, rld_d;
   logic [7:0]       ctrl_q, ctrl_d;
   logic [3:0]       pend_q, pend_d;
   logic [15:0]      presc_q, presc_d;
   logic [15:0]      psc_cnt_q, psc_cnt_d;
   logic [1:0]       irq_id_q, irq_id_d;
   logic [1:0]       ptr_q, ptr_d;
   logic             mem_ready_q, mem_ready_d;

   logic             acc, wr, tick, ack, found;
   logic [3:0]       idx, expire, w1c, ack_clr, req;
   logic [1:0]       cand, pick;
   logic             unused_ok;

   assign unused_ok = &{1'b0, mem_instr, mem_addr[31:6], mem_addr[1:0]};

   assign idx = mem_addr[5:2];
   assign acc = mem_valid & enable & ~mem_ready_q;
   assign wr  = acc & (|mem_wstrb);

   // Prescaler is a down-counter reloaded from PRESC; terminal count is the tick.
   always_comb begin
      mem_ready_d = acc;
      tick        = (psc_cnt_q == 16'd0);
      presc_d     = presc_q;
      psc_cnt_d   = tick ? presc_q : psc_cnt_q - 16'd1;
      if (wr && idx == A_PRESC) begin
         presc_d   = mem_wdata[15:0];
         psc_cnt_d = mem_wdata[15:0];
      end
      ctrl_d = (wr && idx == A_CTRL) ? mem_wdata[7:0] : ctrl_q;
      cnt_d  = cnt_q;
      rld_d  = rld_q;
      expire = '0;
      for (int n = 0; n < 4; n++) begin
         if (tick && ctrl_q[n]) begin
            if (cnt_q[n] == 32'd1) begin
               cnt_d[n]  = rld_q[n];
               expire[n] = 1'b1;
            end else if (cnt_q[n] != 32'd0) begin
               cnt_d[n] = cnt_q[n] - 32'd1;
            end
         end
         // a bus load of the count overrides a coincident expiry
         if (wr && idx == 4'(n)) begin
            cnt_d[n]  = mem_wdata;
            expire[n] = 1'b0;
         end
         if (wr && idx == 4'(n + 4)) begin
            rld_d[n] = mem_wdata;
         end
      end
      ack     = wr && (idx == A_CUR) && (state_q == ST_GRANT);
      w1c     = (wr && idx == A_PEND) ? mem_wdata[3:0] : 4'b0000;
      ack_clr = ack ? (4'b0001 << irq_id_q) : 4'b0000;
      pend_d  = (pend_q & ~w1c & ~ack_clr) | expire;
   end

   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      ptr_d    = ptr_q;
      req      = pend_q & ctrl_q[7:4];
      found    = 1'b0;
      pick     = ptr_q;
      cand     = ptr_q;
      for (int i = 1; i <= 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d  = ST_GRANT;
               irq_id_d = pick;
               ptr_d    = pick;
            end
         end
         ST_GRANT: begin
            if (ack || !req[irq_id_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rld_q       <= '0;
         ctrl_q      <= '0;
         pend_q      <= '0;
         presc_q     <= '0;
         psc_cnt_q   <= '0;
         irq_id_q    <= 2'd0;
         ptr_q       <= 2'd3;
         mem_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rld_q       <= rld_d;
         ctrl_q      <= ctrl_d;
         pend_q      <= pend_d;
         presc_q     <= presc_d;
         psc_cnt_q   <= psc_cnt_d;
         irq_id_q    <= irq_id_d;
         ptr_q       <= ptr_d;
         mem_ready_q <= mem_ready_d;
      end
   end

   assign irq       = (state_q == ST_GRANT);
   assign irq_id    = irq_id_q;
   assign mem_ready = mem_ready_q;

   always_comb begin
      mem_rdata = 32'd0;
      case (idx)
         4'h0, 4'h1, 4'h2, 4'h3: mem_rdata = cnt_q[idx[1:0]];
         4'h4, 4'h5, 4'h6, 4'h7: mem_rdata = rld_q[idx[1:0]];
         A_CTRL:                 mem_rdata = {24'd0, ctrl_q};
         A_PEND:                 mem_rdata = {28'd0, pend_q};
         A_CUR:                  mem_rdata = {irq, 29'd0, irq_id};
         A_PRESC:                mem_rdata = {16'd0, presc_q};
         default:                mem_rdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_timer_irq_sched.sv
// Scoreboarded bench for timer_irq_sched: directed scenarios plus random
// bus traffic checked against a cycle-level behavioural model.
module tb_timer_irq_sched;

   logic        clk = 1'b0;
   logic        resetn;
   logic        enable, mem_valid, mem_instr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata, mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        irq;
   logic [1:0]  irq_id;

   int n_checks = 0;
   int n_pass   = 0;

   timer_irq_sched dut (
      .clk       (clk),
      .resetn    (resetn),
      .enable    (enable),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_instr (mem_instr),
      .mem_wstrb (mem_wstrb),
      .mem_wdata (mem_wdata),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .irq       (irq),
      .irq_id    (irq_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   // Reference model state
   logic [31:0] m_cnt [4];
   logic [31:0] m_rel [4];
   logic [7:0]  m_ctrl;
   logic [3:0]  m_pend;
   int          m_presc, m_pc;
   bit          m_grant;
   int          m_id, m_ptr;
   bit          m_ready;
   logic [31:0] exp_q [$];
   logic [31:0] mon_exp;
   int          cyc = 0;
   int          acc_cyc = 0;

   function automatic logic [31:0] model_read(input int idx);
      case (idx)
         0, 1, 2, 3: return m_cnt[idx];
         4, 5, 6, 7: return m_rel[idx-4];
         8:          return {24'd0, m_ctrl};
         9:          return {28'd0, m_pend};
         10:         return {m_grant, 29'd0, 2'(m_id)};
         11:         return 32'(m_presc);
         default:    return 32'd0;
      endcase
   endfunction

   task automatic model_step();
      bit         acc, wr, tick, ack;
      int         idx, c;
      logic [3:0] set, clr;
      cyc++;
      acc  = mem_valid && enable && !m_ready;
      wr   = acc && (mem_wstrb != 4'd0);
      idx  = int'(mem_addr[5:2]);
      tick = (m_pc == m_presc);
      set  = 4'd0;
      clr  = 4'd0;
      for (int n = 0; n < 4; n++) begin
         if (tick && m_ctrl[n] && m_cnt[n] != 0) begin
            if (m_cnt[n] == 1) begin
               m_cnt[n] = m_rel[n];
               set[n]   = 1'b1;
            end else begin
               m_cnt[n] = m_cnt[n] - 1;
            end
         end
         if (wr && idx == n) begin
            m_cnt[n] = mem_wdata;
            set[n]   = 1'b0;
         end
      end
      ack = wr && idx == 10 && m_grant;
      if (wr && idx == 9) clr = mem_wdata[3:0];
      if (ack) clr[m_id] = 1'b1;
      if (m_grant) begin
         if (ack || !m_pend[m_id] || !m_ctrl[4+m_id]) m_grant = 1'b0;
      end else begin
         for (int k = 1; k <= 4; k++) begin
            c = (m_ptr + k) % 4;
            if (!m_grant && m_pend[c] && m_ctrl[4+c]) begin
               m_grant = 1'b1;
               m_id    = c;
               m_ptr   = c;
            end
         end
      end
      m_pend = (m_pend & ~clr) | set;
      if (wr && idx >= 4 && idx <= 7) m_rel[idx-4] = mem_wdata;
      if (wr && idx == 8) m_ctrl = mem_wdata[7:0];
      if (wr && idx == 11) begin
         m_presc = int'(mem_wdata[15:0]);
         m_pc    = 0;
      end else begin
         m_pc = tick ? 0 : m_pc + 1;
      end
      m_ready = acc;
      if (acc) begin
         acc_cyc = cyc;
         exp_q.push_back(model_read(idx));
      end
   endtask

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int n = 0; n < 4; n++) begin
            m_cnt[n] = 32'd0;
            m_rel[n] = 32'd0;
         end
         m_ctrl  = 8'd0;
         m_pend  = 4'd0;
         m_presc = 0;
         m_pc    = 0;
         m_grant = 1'b0;
         m_id    = 0;
         m_ptr   = 3;
         m_ready = 1'b0;
         exp_q.delete();
      end else begin
         model_step();
      end
   end

   // Monitor: compares DUT outputs with the model away from the active edge
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         chk("ready", 32'(mem_ready), 32'(m_ready));
         chk("irq", 32'(irq), 32'(m_grant));
         if (m_grant) chk("irq_id", 32'(irq_id), 32'(m_id));
         if (mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("rdata_unexpected_ready", 32'(mem_ready), 32'd0);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("rdata", mem_rdata, mon_exp);
            end
         end
      end
   end

   task automatic bus(input logic [3:0] idx, input logic [3:0] strb,
                      input logic [31:0] data, output logic [31:0] rd);
      logic [31:0] a;
      a      = $urandom();
      a[5:2] = idx;
      a[1:0] = 2'b00;
      @(posedge clk); #1;
      mem_valid = 1'b1;
      enable    = 1'b1;
      mem_addr  = a;
      mem_wstrb = strb;
      mem_wdata = data;
      mem_instr = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      rd = mem_rdata;
      @(posedge clk); #1;
      mem_valid = 1'b0;
      mem_wstrb = 4'd0;
   endtask

   task automatic wr(input logic [3:0] idx, input logic [31:0] data);
      logic [31:0] d;
      bus(idx, 4'($urandom_range(1, 15)), data, d);
   endtask

   task automatic rd_chk(input string nm, input logic [3:0] idx, input logic [31:0] exp);
      logic [31:0] d;
      bus(idx, 4'd0, $urandom(), d);
      chk(nm, d, exp);
   endtask

   task automatic wait_irq(input string nm, input logic [1:0] exp_id, output int seen);
      int n;
      n = 0;
      @(negedge clk);
      while (irq !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      seen = cyc;
      chk({nm, "_irq"}, 32'(irq), 32'd1);
      chk({nm, "_id"}, 32'(irq_id), 32'(exp_id));
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      resetn    = 1'b0;
      mem_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int          seen, a;
      logic [3:0]  ridx, rs;
      logic [31:0] rdat, d;

      resetn    = 1'b0;
      enable    = 1'b0;
      mem_valid = 1'b0;
      mem_instr = 1'b0;
      mem_wstrb = 4'd0;
      mem_wdata = 32'd0;
      mem_addr  = 32'd0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;

      // One-shot
      wr(4'h8, 32'h11);
      wr(4'h0, 32'd5);
      a = acc_cyc;
      wait_irq("oneshot", 2'd0, seen);
      chk("oneshot_latency", 32'(seen - a), 32'd6);
      rd_chk("oneshot_cnt0", 4'h0, 32'd0);
      rd_chk("oneshot_pend", 4'h9, 32'd1);
      wr(4'hA, $urandom());
      chk("oneshot_ack_irq", 32'(irq), 32'd0);
      rd_chk("oneshot_pend_clr", 4'h9, 32'd0);
      rd_chk("oneshot_cnt0_stay", 4'h0, 32'd0);

      // Periodic
      do_reset();
      wr(4'hB, 32'd1);
      wr(4'h5, 32'd3);
      wr(4'h1, 32'd3);
      wr(4'h8, 32'h22);
      wait_irq("periodic0", 2'd1, seen);
      for (int k = 0; k < 3; k++) begin
         a = seen;
         wr(4'hA, $urandom());
         wait_irq("periodic", 2'd1, seen);
         chk("periodic_interval", 32'(seen - a), 32'd6);
      end

      // Round-robin
      do_reset();
      for (int n = 0; n < 4; n++) wr(4'(n), 32'd1);
      wr(4'h8, 32'hFF);
      for (int n = 0; n < 4; n++) begin
         wait_irq("rr_first", 2'(n), seen);
         wr(4'hA, $urandom());
      end
      wr(4'h8, 32'hF0);
      wr(4'h0, 32'd1);
      wr(4'h2, 32'd1);
      wr(4'h8, 32'hFF);
      wait_irq("rr_second_a", 2'd0, seen);
      wr(4'hA, $urandom());
      wait_irq("rr_second_b", 2'd2, seen);
      wr(4'hA, $urandom());
      chk("rr_done_irq", 32'(irq), 32'd0);

      // Masking
      do_reset();
      wr(4'h8, 32'h01);
      wr(4'h0, 32'd1);
      repeat (4) @(negedge clk);
      chk("mask_off_irq", 32'(irq), 32'd0);
      wr(4'h8, 32'h11);
      a = acc_cyc;
      wait_irq("mask_on", 2'd0, seen);
      chk("mask_on_latency", 32'(seen - a), 32'd1);
      wr(4'h8, 32'h01);
      chk("mask_clr_irq", 32'(irq), 32'd0);

      // Collision: W1C against expiry
      do_reset();
      wr(4'h8, 32'h01);
      wr(4'h0, 32'd3);
      wr(4'h9, 32'h1);
      rd_chk("coll_w1c_pend", 4'h9, 32'd1);

      // Collision: CNT write against expiry
      do_reset();
      wr(4'h8, 32'h04);
      wr(4'h2, 32'd3);
      wr(4'h2, 32'd9);
      wr(4'h8, 32'h00);
      rd_chk("coll_cnt2", 4'h2, 32'd6);
      rd_chk("coll_pend2", 4'h9, 32'd0);

      // Asynchronous reset mid-GRANT with a bus acknowledge in flight
      do_reset();
      wr(4'h8, 32'h44);
      wr(4'h2, 32'd1);
      wait_irq("rst_setup", 2'd2, seen);
      @(posedge clk); #1;
      mem_valid = 1'b1;
      enable    = 1'b1;
      mem_addr  = 32'h28;
      mem_wstrb = 4'd0;
      @(posedge clk); #3;
      chk("rst_pre_ready", 32'(mem_ready), 32'd1);
      resetn = 1'b0;
      #1;
      chk("rst_async_irq", 32'(irq), 32'd0);
      chk("rst_async_ready", 32'(mem_ready), 32'd0);
      chk("rst_async_irq_id", 32'(irq_id), 32'd0);
      mem_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      for (int n = 0; n < 12; n++) rd_chk("post_reset_reg", 4'(n), 32'd0);

      // Random traffic against the model
      do_reset();
      for (int t = 0; t < 400; t++) begin
         ridx = 4'($urandom_range(0, 15));
         if (irq === 1'b1 && $urandom_range(0, 2) == 0) ridx = 4'hA;
         rs = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         case (ridx)
            4'h0, 4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h6, 4'h7: rdat = 32'($urandom_range(0, 10));
            4'hB:                   rdat = 32'($urandom_range(0, 3));
            default:                rdat = $urandom();
         endcase
         bus(ridx, rs, rdat, d);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #1;
            mem_valid = 1'b1;
            enable    = 1'b0;
            mem_wstrb = 4'hF;
            mem_wdata = $urandom();
            @(posedge clk); #1;
            mem_valid = 1'b0;
            mem_wstrb = 4'd0;
            enable    = 1'b1;
         end
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
